ex_muldiv: RTL and testbench
============================

EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (even, >=8).
REQ-002 SHALL have parameter REG_IDX_W, default 5, destination register index width.
REQ-003 SHALL have port clk_in  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start_in  input  1  request to begin an operation.
REQ-006 SHALL have port flush_in  input  1  pipeline jump/flush; aborts the current operation.
REQ-007 SHALL have port op_in  input  3  funct3 code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-008 SHALL have port rs1Data_in  input  XLEN  multiplicand/dividend.
REQ-009 SHALL have port rs2Data_in  input  XLEN  multiplier/divisor.
REQ-010 SHALL have port rdIdx_in  input  REG_IDX_W  destination register index.
REQ-011 SHALL have port busy_out  output  1  high while state != IDLE; ID/IF stall on it.
REQ-012 SHALL have port done_out  output  1  one-cycle result-valid pulse.
REQ-013 SHALL have port result_out  output  XLEN  registered result.
REQ-014 SHALL have port rdIdx_out  output  REG_IDX_W  destination index captured at start.

Function
REQ-015 SHALL implement the state machine IDLE -> CALC -> DONE -> IDLE.
REQ-016 In IDLE, start_in=1 with flush_in=0 at edge N SHALL capture op, operands and rdIdx_in, and SHALL enter CALC with iteration counter 0.
REQ-017 CALC SHALL perform one shift-add (multiply) or one restoring-subtract (divide) iteration per edge, on operand magnitudes, for exactly XLEN edges, then SHALL enter DONE.
REQ-018 Normal latency SHALL be XLEN+1 edges: done_out=1 in the cycle following edge N+XLEN.
REQ-019 DONE SHALL last exactly one cycle with done_out=1, and SHALL then return to IDLE.
REQ-020 result_out and rdIdx_out SHALL hold their values until the next completion.
REQ-021 Divisor zero SHALL take IDLE->DONE directly (done_out=1 after edge N) and SHALL return quotient all-ones, remainder = dividend.
REQ-022 Signed overflow (DIV/REM with dividend 2^(XLEN-1), divisor -1) SHALL take IDLE->DONE directly and SHALL return quotient = dividend, remainder 0.
REQ-023 Signed result correction: quotient negated if the operand signs differ; remainder takes the dividend's sign; MULH is signed x signed, MULHSU is signed rs1 x unsigned rs2, MULHU is unsigned; MUL returns the low XLEN bits and MULH* return the high XLEN bits of the 2*XLEN product.
REQ-024 start_in SHALL be ignored while state != IDLE, including in DONE.
REQ-025 flush_in=1 SHALL force IDLE at the next edge from any state and SHALL suppress done_out; flush_in SHALL have priority over a simultaneous start_in.
REQ-026 busy_out SHALL be registered, i.e. a function of state only, with no combinational path from start_in.

Reset
REQ-027 rst_in=1 SHALL immediately force IDLE, counter 0, busy_out 0, done_out 0, result_out 0, rdIdx_out 0, and all internal operand registers to 0.
REQ-028 Reset asserted mid-operation SHALL discard the operation; no done_out pulse follows reset release.

Configuration
REQ-029 Macro MULDIV_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU SHALL compute the full product combinationally and go IDLE->DONE at edge N (latency 1); divides are unchanged.
REQ-030 Macro MULDIV_FAST_MUL_EN undefined: all multiplies SHALL use the iterative CALC path with latency XLEN+1; no multiplier array is synthesised.

Verification (XLEN=32)
REQ-031 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB; done_out 33 edges after start (1 edge with MULDIV_FAST_MUL_EN).
REQ-032 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-033 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; rdIdx_out equals rdIdx_in given at start.
REQ-034 DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; each with done_out 1 edge after start.
REQ-035 DIV started, flush_in pulsed at the 10th CALC edge -> busy_out 0 next cycle, no done_out; a new start in the following cycle is accepted and completes normally.
REQ-036 rst_in pulsed mid-CALC, asynchronously between edges -> all outputs 0 immediately; start_in held high during CALC is ignored, and back-to-back starts complete in order with single-cycle done pulses.

Source files
------------

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative integer multiply/divide unit for the EX stage.
//   Multiplies use shift-add, divides use restoring subtraction, both on
//   operand magnitudes with a sign fix-up at the end. One iteration per
//   clock, XLEN iterations; divide-by-zero and signed overflow finish at
//   once.
//   Optional macro MULDIV_FAST_MUL_EN: multiplies complete in a single
//   cycle via a combinational multiplier.
// Ports:
//   clk_in, rst_in (async, active-high)
//   start_in, flush_in, op_in (funct3), rs1Data_in, rs2Data_in, rdIdx_in
//   busy_out (state != IDLE), done_out (1-cycle pulse),
//   result_out, rdIdx_out (held until the next completion)
module ex_muldiv #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic                 flush_in,
  input  logic [2:0]           op_in,
  input  logic [XLEN-1:0]      rs1Data_in,
  input  logic [XLEN-1:0]      rs2Data_in,
  input  logic [REG_IDX_W-1:0] rdIdx_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic [XLEN-1:0]      result_out,
  output logic [REG_IDX_W-1:0] rdIdx_out
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             op_q, op_d;
  logic [2*XLEN-1:0]      acc_q, acc_d;     // {hi/rem, lo/quotient}
  logic [XLEN-1:0]        b_q, b_d;         // |multiplier| or |divisor|
  logic                   qneg_q, qneg_d;   // negate product/quotient
  logic                   rneg_q, rneg_d;   // negate remainder
  logic [REG_IDX_W-1:0]   rd_cap_q, rd_cap_d, rd_out_q, rd_out_d;
  logic [XLEN-1:0]        res_q, res_d;
  logic                   busy_q, busy_d, done_q, done_d;

  // Request decode: signedness per funct3, magnitudes, early-out cases
  logic            a_sgn, b_sgn, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;
  always_comb begin
    a_sgn    = rs1Data_in[XLEN-1] &
               (op_in == 3'd1 || op_in == 3'd2 || op_in == 3'd4 || op_in == 3'd6);
    b_sgn    = rs2Data_in[XLEN-1] & (op_in == 3'd1 || op_in == 3'd4 || op_in == 3'd6);
    a_mag    = a_sgn ? -rs1Data_in : rs1Data_in;
    b_mag    = b_sgn ? -rs2Data_in : rs2Data_in;
    div_zero = op_in[2] && (rs2Data_in == '0);
    div_ovf  = op_in[2] && !op_in[0] &&
               (rs1Data_in == {1'b1, {(XLEN-1){1'b0}}}) && (rs2Data_in == '1);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_p;
  always_comb begin
    // a_sgn/b_sgn are already masked per op, so sign-extension is correct
    fast_a = {{XLEN{a_sgn}}, rs1Data_in};
    fast_b = {{XLEN{b_sgn}}, rs2Data_in};
    fast_p = fast_a * fast_b;
  end
`endif

  // One iteration plus the final sign fix-up on the post-iteration value,
  // so the result can be registered on the same edge as the last step.
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] acc_step, prod;
  logic [XLEN-1:0]   quo, rem, calc_res;
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_sh - {1'b0, b_q};
    if (!op_q[2])
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    else if (!div_diff[XLEN])
      acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      acc_step = {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    prod = qneg_q ? -acc_step : acc_step;
    quo  = qneg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem  = rneg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    if (!op_q[2])
      calc_res = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else
      calc_res = op_q[1] ? rem : quo;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    b_d      = b_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    rd_cap_d = rd_cap_q;
    rd_out_d = rd_out_q;
    res_d    = res_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (start_in) begin
        op_d     = op_in;
        rd_cap_d = rdIdx_in;
        acc_d    = {{XLEN{1'b0}}, a_mag};
        b_d      = b_mag;
        qneg_d   = a_sgn ^ b_sgn;
        rneg_d   = a_sgn;
        cnt_d    = '0;
        if (div_zero) begin
          res_d    = op_in[1] ? rs1Data_in : '1;
          rd_out_d = rdIdx_in;
          done_d   = 1'b1;
          state_d  = DONE;
        end else if (div_ovf) begin
          res_d    = op_in[1] ? '0 : rs1Data_in;
          rd_out_d = rdIdx_in;
          done_d   = 1'b1;
          state_d  = DONE;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!op_in[2]) begin
          res_d    = (op_in[1:0] == 2'd0) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
          rd_out_d = rdIdx_in;
          done_d   = 1'b1;
          state_d  = DONE;
        end
`endif
        else begin
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) begin
          res_d    = calc_res;
          rd_out_d = rd_cap_q;
          done_d   = 1'b1;
          cnt_d    = '0;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flush wins over everything: abort, no completion, outputs keep old values
    if (flush_in) begin
      state_d  = IDLE;
      cnt_d    = '0;
      done_d   = 1'b0;
      res_d    = res_q;
      rd_out_d = rd_out_q;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      rd_cap_q <= '0;
      rd_out_q <= '0;
      res_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      rd_cap_q <= rd_cap_d;
      rd_out_q <= rd_out_d;
      res_q    <= res_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_out   = busy_q;
  assign done_out   = done_q;
  assign result_out = res_q;
  assign rdIdx_out  = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed-vector bench for ex_muldiv (XLEN=32) with an
// arithmetic reference model and a per-cycle compare process.
module tb_ex_muldiv;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  rd = '0;
  logic        busy, done;
  logic [31:0] res;
  logic [4:0]  rdo;

  ex_muldiv #(.XLEN(32), .REG_IDX_W(5)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .flush_in(flush),
    .op_in(op), .rs1Data_in(a), .rs2Data_in(b), .rdIdx_in(rd),
    .busy_out(busy), .done_out(done), .result_out(res), .rdIdx_out(rdo)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int cap; logic [31:0] res; logic [4:0] rd; } exp_t;
  typedef struct { logic [2:0] op; logic [31:0] x; logic [31:0] y; logic [31:0] r; } vec_t;

  exp_t        exq[$];
  vec_t        vecs[17];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference arithmetic straight from the RISC-V M definitions
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint ux = longint'({32'b0, x});
    longint uy = longint'({32'b0, y});
    logic [63:0] p;
    logic ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = ux * uy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'($signed(x) / $signed(y));
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: return (y == 0) ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Edges from start capture to visible done, counting the capture edge
  function automatic int lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    if (o[2]) return (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) ? 1 : 33;
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  // Compare process: checks done/busy/result/rdIdx against the model every cycle
  always @(posedge clk) begin
    int exp_busy;
    #1;
    cyc++;
    if (exq.size() > 0 && exq[0].due == cyc) begin
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_in_done", 32'(busy), 32'd1);
      last_res = exq[0].res;
      last_rd  = exq[0].rd;
      exq.delete(0);
    end else begin
      exp_busy = (exq.size() > 0 && exq[0].cap <= cyc) ? 1 : 0;
      chk("no_done", 32'(done), 32'd0);
      chk("busy", 32'(busy), 32'(exp_busy));
    end
    chk("result_out", res, last_res);
    chk("rdIdx_out", 32'(rdo), 32'(last_rd));
  end

  // Drive a request at the current negedge; hold start for 'hold' cycles
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] r, input int hold);
    op = o; a = x; b = y; rd = r; start = 1'b1;
    exq.push_back('{due: cyc + lat(o, x, y), cap: cyc + 1, res: model(o, x, y), rd: r});
    repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && exq.size() > 0; n++) @(negedge clk);
    if (exq.size() > 0) begin
      chk("completion_timeout", 32'(exq.size()), 32'd0);
      exq.delete();
    end
  endtask

  initial begin
    vecs = '{
      '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
      '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
      '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
      '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
      '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
      '{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF},
      '{3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005},
      '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
      '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
      '{3'd5, 32'd100,       32'd7,         32'd14},
      '{3'd7, 32'd100,       32'd7,         32'd2},
      '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1},
      '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD},
      '{3'd1, 32'hFFFF_FFFF, 32'd5,         32'hFFFF_FFFF},
      '{3'd4, 32'd4,         32'd0,         32'hFFFF_FFFF},
      '{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9}
    };

    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", res, 32'd0);
    chk("reset_rdidx", 32'(rdo), 32'd0);
    rst = 1'b0;

    // Pin the reference model to hand-computed answers
    foreach (vecs[i]) chk($sformatf("model_vec%0d", i), model(vecs[i].op, vecs[i].x, vecs[i].y), vecs[i].r);

    foreach (vecs[i]) begin
      @(negedge clk);
      issue(vecs[i].op, vecs[i].x, vecs[i].y, 5'(i + 1), 1);
      wait_idle();
      chk($sformatf("vec%0d_result", i), res, vecs[i].r);
      chk($sformatf("vec%0d_rdidx", i), 32'(rdo), 32'(i + 1));
    end

    // Start raised during DONE is ignored, then accepted once IDLE
    @(negedge clk);
    issue(3'd5, 32'd100, 32'd7, 5'd20, 1);
    wait_idle();
    op = 3'd4; a = 32'hFFFF_FFF9; b = 32'd2; rd = 5'd21; start = 1'b1;
    exq.push_back('{due: cyc + 1 + lat(3'd4, a, b), cap: cyc + 2, res: 32'hFFFF_FFFD, rd: 5'd21});
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk("b2b_result", res, 32'hFFFF_FFFD);
    chk("b2b_rdidx", 32'(rdo), 32'd21);

    // Start held high through CALC is ignored
    @(negedge clk);
    issue(3'd4, 32'd1000, 32'd3, 5'd22, 20);
    wait_idle();
    chk("held_start_result", res, 32'd333);

    // Flush on the 10th CALC edge, then a new start the next cycle
    @(negedge clk);
    issue(3'd4, 32'd1000, 32'd7, 5'd23, 1);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    exq.delete();
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_result_kept", res, 32'd333);
    issue(3'd6, 32'd1000, 32'd7, 5'd24, 1);
    wait_idle();
    chk("after_flush_result", res, 32'd6);
    chk("after_flush_rdidx", 32'(rdo), 32'd24);

    // Flush has priority over a simultaneous start
    @(negedge clk);
    op = 3'd4; a = 32'd50; b = 32'd5; rd = 5'd30; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_vs_start_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    issue(3'd4, 32'd1000, 32'd3, 5'd25, 1);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    exq.delete();
    last_res = '0;
    last_rd  = '0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_result", res, 32'd0);
    chk("async_rst_rdidx", 32'(rdo), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    @(negedge clk);
    issue(3'd0, 32'd3, 32'd5, 5'd26, 1);
    wait_idle();
    chk("post_reset_result", res, 32'd15);
    chk("post_reset_rdidx", 32'(rdo), 32'd26);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
